// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, jr/jump redirects and two-cycle taken branches,
// with all address arithmetic done on an external 32-bit adder.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_ci,
  input  logic [31:0] add_sum,
  input  logic        add_co,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_SEQ  = 2'd1,
    S_BR   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] off_q, off_d;
  logic        misalign_q, misalign_d;

  // PC wraps modulo 2^32, so the adder carry-out carries no information.
  logic unused_add_co;
  assign unused_add_co = add_co;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_VECTOR;
      pc4_q      <= 32'd0;
      off_q      <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc4_q      <= pc4_d;
      off_q      <= off_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc4_d      = pc4_q;
    off_d      = off_q;
    misalign_d = 1'b0;
    if (!stall) begin
      case (state_q)
        S_BOOT: state_d = S_SEQ;
        S_SEQ: begin
          if (jr) begin
            pc_d       = jr_addr & ~32'h3;
            misalign_d = |jr_addr[1:0];
          end else if (jump) begin
            pc_d = {add_sum[31:28], jump_target, 2'b00};
          end else if (branch_taken) begin
            // Keep pc+4 and the byte offset so the adder can form the target next cycle.
            pc4_d   = add_sum;
            off_d   = {{14{branch_imm[15]}}, branch_imm, 2'b00};
            state_d = S_BR;
          end else begin
            pc_d = add_sum;
          end
        end
        S_BR: begin
          pc_d    = add_sum;
          state_d = S_SEQ;
        end
        default: state_d = S_BOOT;
      endcase
    end
  end

  always_comb begin
    if (state_q == S_BR) begin
      add_a = pc4_q;
      add_b = off_q;
    end else begin
      add_a = pc_q;
      add_b = 32'd4;
    end
  end

  assign add_ci       = 1'b0;
  assign pc           = pc_q;
  assign pc_valid     = (state_q == S_SEQ);
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model queues expected outputs per cycle and a
// negedge monitor compares them against the DUT, plus directed checks on the key scenarios.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, jump = 1'b0, jr = 1'b0, branch_taken = 1'b0;
  logic [25:0] jump_target = '0;
  logic [31:0] jr_addr = '0;
  logic [15:0] branch_imm = '0;
  logic [31:0] add_a, add_b, add_sum, pc;
  logic        add_ci, add_co, pc_valid, misalign_err;

  always #5 clk = ~clk;

  // External ripple adder stand-in.
  assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_ci};

  pc_sequencer #(.RESET_VECTOR(RV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .jump         (jump),
    .jump_target  (jump_target),
    .jr           (jr),
    .jr_addr      (jr_addr),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_ci       (add_ci),
    .add_sum      (add_sum),
    .add_co       (add_co),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .misalign_err (misalign_err)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  // Model: 0 = booting, 1 = sequencing, 2 = taken branch waiting for its target.
  int          m_mode;
  logic [31:0] m_pc, m_ret, m_off;
  logic        m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_obs();
    exp_t e;
    e.pc    = m_pc;
    e.valid = (m_mode == 1);
    e.a     = (m_mode == 2) ? m_ret : m_pc;
    e.b     = (m_mode == 2) ? m_off : 32'd4;
    e.mis   = m_mis;
    return e;
  endfunction

  function automatic void model_reset();
    m_mode = 0;
    m_pc   = RV;
    m_ret  = 32'd0;
    m_off  = 32'd0;
    m_mis  = 1'b0;
  endfunction

  function automatic void model_step(input logic st, input logic j_r, input logic [31:0] ja,
                                     input logic jp, input logic [25:0] jt, input logic bt,
                                     input logic [15:0] bi);
    logic [31:0] seq_pc;
    seq_pc = m_pc + 32'd4;
    m_mis  = 1'b0;
    if (st) return;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 2) begin
      m_pc   = m_ret + m_off;
      m_mode = 1;
    end else if (j_r) begin
      m_pc  = {ja[31:2], 2'b00};
      m_mis = (ja[1:0] != 2'b00);
    end else if (jp) begin
      m_pc = {seq_pc[31:28], jt, 2'b00};
    end else if (bt) begin
      m_ret  = seq_pc;
      m_off  = 32'(signed'(bi)) * 32'd4;
      m_mode = 2;
    end else begin
      m_pc = seq_pc;
    end
  endfunction

  // Called at posedge+2; applies inputs for one cycle and queues the outcome after the next edge.
  task automatic step(input logic st, input logic j_r, input logic [31:0] ja, input logic jp,
                      input logic [25:0] jt, input logic bt, input logic [15:0] bi);
    stall = st; jr = j_r; jr_addr = ja; jump = jp; jump_target = jt;
    branch_taken = bt; branch_imm = bi;
    model_step(st, j_r, ja, jp, jt, bt, bi);
    q.push_back(model_obs());
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 16'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, RV);
    chk("rst_valid", {31'd0, pc_valid}, 32'd0);
    chk("rst_mis", {31'd0, misalign_err}, 32'd0);
    mon_en = 1'b0;
    q.delete();
    stall = 1'b0; jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    q.push_back(model_obs());
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_pc", pc, e.pc);
        chk("sb_valid", {31'd0, pc_valid}, {31'd0, e.valid});
        chk("sb_add_a", add_a, e.a);
        chk("sb_add_b", add_b, e.b);
        chk("sb_mis", {31'd0, misalign_err}, {31'd0, e.mis});
        chk("sb_add_ci", {31'd0, add_ci}, 32'd0);
      end
    end
  end

  initial begin
    model_reset();
    @(posedge clk);
    #2;
    do_reset();

    // Boot then free-running fetch.
    chk("boot_pc", pc, 32'h0);
    chk("boot_valid", {31'd0, pc_valid}, 32'd0);
    idle(); chk("seq0_pc", pc, 32'h0); chk("seq0_valid", {31'd0, pc_valid}, 32'd1);
    idle(); chk("seq1_pc", pc, 32'h4);
    idle(); chk("seq2_pc", pc, 32'h8);
    idle(); chk("seq3_pc", pc, 32'hC);

    // Backward taken branch to itself.
    step(1'b0, 1'b1, 32'h0000_1000, 1'b0, 26'd0, 1'b0, 16'd0);
    chk("jr_pc", pc, 32'h0000_1000);
    step(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 16'hFFFF);
    chk("br_add_a", add_a, 32'h0000_1004);
    chk("br_add_b", add_b, 32'hFFFF_FFFC);
    chk("br_valid", {31'd0, pc_valid}, 32'd0);
    idle(); chk("br_pc", pc, 32'h0000_1000);

    // J-type keeps the top nibble of pc+4.
    step(1'b0, 1'b1, 32'hF000_0010, 1'b0, 26'd0, 1'b0, 16'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 26'h000_0040, 1'b0, 16'd0);
    chk("jump_pc", pc, 32'hF000_0100);

    // All requests at once: jr wins, misaligned target pulses the error.
    step(1'b0, 1'b1, 32'h0000_2003, 1'b1, 26'h3FF_FFFF, 1'b1, 16'h0100);
    chk("prio_pc", pc, 32'h0000_2000);
    chk("prio_mis", {31'd0, misalign_err}, 32'd1);
    idle();
    chk("prio_mis_clr", {31'd0, misalign_err}, 32'd0);
    chk("prio_next_pc", pc, 32'h0000_2004);

    // Stall held in the branch state.
    step(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 16'h0010);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 32'h0000_0123, 1'b1, 26'd5, 1'b1, 16'h0004);
      chk("stall_pc", pc, 32'h0000_2004);
      chk("stall_add_a", add_a, 32'h0000_2008);
      chk("stall_add_b", add_b, 32'h0000_0040);
    end
    idle(); chk("stall_br_pc", pc, 32'h0000_2048);

    // Wrap-around, then reset while a branch is pending.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'd0, 1'b0, 16'd0);
    idle(); chk("wrap_pc", pc, 32'h0000_0000);
    step(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 16'h8000);
    chk("mid_br_valid", {31'd0, pc_valid}, 32'd0);
    do_reset();
    chk("rel_valid", {31'd0, pc_valid}, 32'd0);
    idle(); chk("rel_pc", pc, RV); chk("rel_seq_valid", {31'd0, pc_valid}, 32'd1);

    // Randomized traffic, occasional resets.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, $urandom,
             $urandom_range(0, 9) == 0, 26'($urandom), $urandom_range(0, 5) == 0,
             16'($urandom));
      end
    end

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset; bits [1:0] SHALL be 0.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 stall  input  1  hold PC and state when 1; outputs stable.
REQ-005 jump  input  1  J-type redirect request.
REQ-006 jump_target  input  26  J-type word index.
REQ-007 jr  input  1  register-indirect jump request.
REQ-008 jr_addr  input  32  jr byte target.
REQ-009 branch_taken  input  1  resolved taken branch.
REQ-010 branch_imm  input  16  signed word offset of branch.
REQ-011 add_a  output  32  operand A to the external 32-bit ripple adder.
REQ-012 add_b  output  32  operand B to the external adder.
REQ-013 add_ci  output  1  adder carry-in; constant 0.
REQ-014 add_sum  input  32  adder sum, combinational from add_a/add_b/add_ci in the same cycle.
REQ-015 add_co  input  1  adder carry-out; ignored, and PC wraps modulo 2^32.
REQ-016 pc  output  32  current fetch address.
REQ-017 pc_valid  output  1  1 when pc is a valid fetch address this cycle.
REQ-018 misalign_err  output  1  one-cycle pulse on a misaligned jr target.

Function
REQ-019 FSM states SHALL be: S_BOOT, S_SEQ, S_BR.
REQ-020 S_BOOT: pc_valid=0; the next edge SHALL go to S_SEQ with pc unchanged.
REQ-021 S_SEQ adder drive: add_a=pc, add_b=32'd4, pc_valid=1.
REQ-022 S_SEQ, no request and stall=0: the next edge SHALL load pc<=add_sum and stay in S_SEQ.
REQ-023 Request priority in S_SEQ: jr > jump > branch_taken > sequential; lower-priority requests in the same cycle SHALL be dropped.
REQ-024 jr: pc<=jr_addr & ~32'h3, 1 cycle; misalign_err=1 for that cycle iff jr_addr[1:0]!=0 and stall=0.
REQ-025 jump: pc<={add_sum[31:28], jump_target, 2'b00}, 1 cycle; add_sum is pc+4.
REQ-026 branch_taken: latch pc4_q<=add_sum and off_q<={{14{branch_imm[15]}}, branch_imm, 2'b00}; go to S_BR; pc unchanged.
REQ-027 S_BR: add_a=pc4_q, add_b=off_q, pc_valid=0; the next edge (stall=0) SHALL load pc<=add_sum and go to S_SEQ.
REQ-028 S_BR SHALL ignore jr, jump and branch_taken; branch latency is 2 cycles and each redirect is 1 cycle.
REQ-029 stall=1 in any state: pc, pc4_q, off_q and state held; add_a/add_b follow the held state; misalign_err=0; requests not latched.
REQ-030 Wrap-around: pc=32'hFFFF_FFFC sequential -> 32'h0000_0000; negative offsets wrap modulo 2^32.
REQ-031 All outputs except add_a/add_b SHALL come from registers or from FSM state only; no input-to-output combinational path other than add_sum feeding the next-state logic.

Reset
REQ-032 rst_n=0 SHALL immediately force: pc=RESET_VECTOR, state=S_BOOT, pc4_q=0, off_q=0, pc_valid=0, misalign_err=0, regardless of clk.
REQ-033 Reset asserted mid-branch (S_BR) SHALL abandon the pending branch; after release, the sequence restarts at S_BOOT.
REQ-034 On deassertion, the first rising edge SHALL act as S_BOOT -> S_SEQ.

Verification
REQ-035 Reset release, 4 free cycles -> pc 0,0,4,8,C; pc_valid 0,1,1,1,1.
REQ-036 At pc=32'h0000_1000, branch_taken=1, branch_imm=16'hFFFF -> S_BR with add_a=1004, add_b=FFFF_FFFC, pc_valid=0; next pc=32'h0000_1000.
REQ-037 At pc=32'hF000_0010, jump=1, jump_target=26'h000_0040 -> next pc=32'hF000_0100.
REQ-038 jr=1, jump=1, branch_taken=1 together, jr_addr=32'h0000_2003 -> pc=32'h0000_2000, misalign_err single-cycle pulse.
REQ-039 stall=1 for 3 cycles in S_BR -> pc, add_a, add_b frozen; on release, branch completes next edge.
REQ-040 pc=32'hFFFF_FFFC sequential -> pc=0, add_co ignored; rst_n pulse in S_BR -> pc=RESET_VECTOR asynchronously.
